// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU controller: widths, opcode map
// and controller state encoding.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA = 4'd7;
    localparam logic [OP_W-1:0] ALU_UGT = 4'd8;
    localparam logic [OP_W-1:0] ALU_SGT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU; opcodes 10..15 yield zero and flag illegal.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] c,
    output logic              illegal
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        c       = '0;
        illegal = 1'b0;
        case (op)
            ALU_ADD: c = a + b;
            ALU_SUB: c = a - b;
            ALU_AND: c = a & b;
            ALU_OR:  c = a | b;
            ALU_XOR: c = a ^ b;
            ALU_SLL: c = a << b;
            ALU_SRL: c = a >> b;
            ALU_SRA: c = a_s >>> b;
            ALU_UGT: c = {{(DATA_W-1){1'b0}}, (a > b)};
            ALU_SGT: c = {{(DATA_W-1){1'b0}}, (a_s > b_s)};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one ALU between two valid/ready requesters,
// with a programmable execute hold time and a registered per-requester response.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_c,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_c,
    output logic              rsp1_err
);

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              gnt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] result;
    logic              err;
    logic [DATA_W-1:0] alu_c;
    logic              alu_illegal;
    logic              win0;
    logic              win1;
    logic              accept;
    logic              rsp_take;

    // A tie goes to whichever requester was not granted last.
    assign win0     = req0_valid && (!req1_valid || last_grant);
    assign win1     = req1_valid && (!req0_valid || !last_grant);
    assign accept   = (state == IDLE) && (win0 || win1);
    assign rsp_take = gnt ? rsp1_ready : rsp0_ready;

    assign req0_ready = (state == IDLE) && win0;
    assign req1_ready = (state == IDLE) && win1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win0 || win1) state_nxt = EXEC;
            EXEC:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt        <= win1;
                last_grant <= win1;
                cnt        <= CNT_W'(EXEC_CYCLES - 1);
            end else if (state == EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    result <= alu_c;
                    err    <= alu_illegal;
                end
            end
        end
    end

    // Operands are only captured at the handshake so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= win1 ? req1_a  : req0_a;
            b_q  <= win1 ? req1_b  : req0_b;
            op_q <= win1 ? req1_op : req0_op;
        end
    end

    alu_core u_alu_core (
        .a       (a_q),
        .b       (b_q),
        .op      (op_q),
        .c       (alu_c),
        .illegal (alu_illegal)
    );

    assign rsp0_valid = (state == RESP) && !gnt;
    assign rsp1_valid = (state == RESP) && gnt;
    assign rsp0_c     = gnt ? '0 : result;
    assign rsp1_c     = gnt ? result : '0;
    assign rsp0_err   = !gnt && err;
    assign rsp1_err   = gnt && err;

endmodule
